// File: rtl/hazard_pkg.sv
// rtl/hazard_pkg.sv - shared types and load-use detect helper for the hazard controller
package hazard_pkg;

    localparam int REG_ADDR_W = 5;

    typedef enum logic [1:0] {HZ_IDLE, HZ_STALL, HZ_FLUSH} hz_state_e;

    // Register x0 is hard-wired zero, so a load targeting it never creates a dependency
    function automatic logic load_use(
        input logic [REG_ADDR_W-1:0] rs1,
        input logic [REG_ADDR_W-1:0] rs2,
        input logic                  rs1_en,
        input logic                  rs2_en,
        input logic [REG_ADDR_W-1:0] ex_rd,
        input logic                  ex_load
    );
        return ex_load && (ex_rd != '0) &&
               ((rs1_en && (rs1 == ex_rd)) || (rs2_en && (rs2 == ex_rd)));
    endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// rtl/hazard_ctrl_if.sv - pipeline-side hazard/stall bundle with master and slave views
interface hazard_ctrl_if #(
    parameter int CNT_W = 32
) ();
    import hazard_pkg::*;

    logic [REG_ADDR_W-1:0] i_id_rs1;
    logic [REG_ADDR_W-1:0] i_id_rs2;
    logic                  i_id_rs1_en;
    logic                  i_id_rs2_en;
    logic [REG_ADDR_W-1:0] i_ex_rd;
    logic                  i_ex_mem_rd;
    logic                  i_ex_redirect;
    logic                  o_pc_stall;
    logic                  o_if_id_stall;
    logic                  o_if_id_flush;
    logic                  o_id_ex_flush;
    logic                  o_busy;
    logic [CNT_W-1:0]      o_stall_cnt;
    logic [CNT_W-1:0]      o_flush_cnt;

    modport master (
        output i_id_rs1, i_id_rs2, i_id_rs1_en, i_id_rs2_en, i_ex_rd, i_ex_mem_rd, i_ex_redirect,
        input  o_pc_stall, o_if_id_stall, o_if_id_flush, o_id_ex_flush, o_busy,
               o_stall_cnt, o_flush_cnt
    );

    modport slave (
        input  i_id_rs1, i_id_rs2, i_id_rs1_en, i_id_rs2_en, i_ex_rd, i_ex_mem_rd, i_ex_redirect,
        output o_pc_stall, o_if_id_stall, o_if_id_flush, o_id_ex_flush, o_busy,
               o_stall_cnt, o_flush_cnt
    );

endinterface

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - up-counter that holds at all-ones instead of wrapping
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (inc && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - load-use stall and redirect flush sequencer with perf counters
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int LOAD_STALL_CYC = 1,
    parameter int FLUSH_CYC      = 1,
    parameter int CNT_W          = 32
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    hazard_ctrl_if.slave bus
);

    localparam int MAX_CYC = (LOAD_STALL_CYC > FLUSH_CYC) ? LOAD_STALL_CYC : FLUSH_CYC;
    localparam int SEQ_W   = $clog2(MAX_CYC + 1);

    hz_state_e  state_q, state_d;
    logic [SEQ_W-1:0] cnt_q, cnt_d;

    logic hazard;
    logic pc_stall, if_id_stall, if_id_flush, id_ex_flush, flush_accept;

    assign hazard = load_use(bus.i_id_rs1, bus.i_id_rs2, bus.i_id_rs1_en, bus.i_id_rs2_en,
                             bus.i_ex_rd, bus.i_ex_mem_rd);

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        pc_stall     = 1'b0;
        if_id_stall  = 1'b0;
        if_id_flush  = 1'b0;
        id_ex_flush  = 1'b0;
        flush_accept = 1'b0;
        // A redirect wins everywhere: whatever sits in ID is on the wrong path
        if (bus.i_ex_redirect) begin
            if_id_flush  = 1'b1;
            id_ex_flush  = 1'b1;
            flush_accept = 1'b1;
            if (FLUSH_CYC > 1) begin
                state_d = HZ_FLUSH;
                cnt_d   = SEQ_W'(FLUSH_CYC - 1);
            end else begin
                state_d = HZ_IDLE;
            end
        end else begin
            case (state_q)
                HZ_IDLE: begin
                    if (hazard) begin
                        pc_stall    = 1'b1;
                        if_id_stall = 1'b1;
                        id_ex_flush = 1'b1;
                        if (LOAD_STALL_CYC > 1) begin
                            state_d = HZ_STALL;
                            cnt_d   = SEQ_W'(LOAD_STALL_CYC - 1);
                        end
                    end
                end
                HZ_STALL: begin
                    pc_stall    = 1'b1;
                    if_id_stall = 1'b1;
                    id_ex_flush = 1'b1;
                    cnt_d       = cnt_q - 1'b1;
                    if (cnt_q == SEQ_W'(1)) state_d = HZ_IDLE;
                end
                HZ_FLUSH: begin
                    if_id_flush = 1'b1;
                    id_ex_flush = 1'b1;
                    cnt_d       = cnt_q - 1'b1;
                    if (cnt_q == SEQ_W'(1)) state_d = HZ_IDLE;
                end
                default: state_d = HZ_IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= HZ_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Mealy outputs are gated so nothing leaks out while reset is held
    assign bus.o_pc_stall    = pc_stall    & i_rst_n;
    assign bus.o_if_id_stall = if_id_stall & i_rst_n;
    assign bus.o_if_id_flush = if_id_flush & i_rst_n;
    assign bus.o_id_ex_flush = id_ex_flush & i_rst_n;
    assign bus.o_busy        = (state_q != HZ_IDLE);

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (i_clk),
        .rst_n (i_rst_n),
        .inc   (pc_stall & i_rst_n),
        .cnt   (bus.o_stall_cnt)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (i_clk),
        .rst_n (i_rst_n),
        .inc   (flush_accept & i_rst_n),
        .cnt   (bus.o_flush_cnt)
    );

endmodule
